// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic register placed between two CPU pipeline stages.
//
// A valid/ready handshake wraps a main register M that drives the outputs. When SKID != 0 a
// second register S catches the one beat that is already in flight when the consumer stalls.
// This lets in_ready come straight from a flop, so a stall never ripples combinationally
// upstream. When SKID == 0 only M exists, and in_ready is combinational from out_ready.
//
// Flush either drops every live beat (FLUSH_MODE == 0) or turns it into a bubble by clearing
// the KILL_MASK bits of its control field (FLUSH_MODE != 0). The payload is never altered.
//
// Parameters:
//   DATA_W     payload width (operands, immediates, pc, register addresses)
//   CTRL_W     control-field width
//   KILL_MASK  ctrl bits forced to 0 by a bubble-mode flush
//   SKID       1: two entries, registered in_ready; 0: one entry, combinational in_ready
//   FLUSH_MODE 0: drop (valid cleared); 1: bubble (valid kept, ctrl masked)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-low
//   flush      kill the held entries and the beat accepted this cycle
//   in_valid   upstream beat present
//   in_ready   stage can accept
//   in_data    upstream payload
//   in_ctrl    upstream control
//   out_valid  downstream beat present
//   out_ready  downstream accepts (0 = stall)
//   out_data   head payload
//   out_ctrl   head control
//   occupancy  number of held entries, 0..2

module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK  = {CTRL_W{1'b1}},
  parameter int unsigned       SKID       = 1,
  parameter int unsigned       FLUSH_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Each state's encoding equals the number of held entries, so it drives occupancy directly.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  localparam bit HasSkid     = (SKID != 0);
  localparam bit BubbleFlush = (FLUSH_MODE != 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              fire;

  // ready_q is low only while in reset and for the first cycle after it. With a skid buffer it
  // is also the registered "S is empty" flag.
  assign in_ready  = HasSkid ? ready_q : (ready_q & ((state_q == StEmpty) | out_ready));
  assign out_valid = (state_q != StEmpty);
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign occupancy = state_q;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    case (state_q)
      StEmpty: begin
        if (accept) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (fire && accept) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (fire) begin
          state_d = StEmpty;
        end else if (accept && HasSkid) begin
          // The consumer stalled while a beat was in flight, so park that beat in S.
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
          state_d  = StFull;
        end
      end
      StFull: begin
        // in_ready is low here, so the only possible move is to promote S into M.
        if (fire) begin
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush acts on the post-edge contents. A beat that fires this cycle has already left
    // unmodified, and a beat accepted this cycle is treated like any other live entry.
    if (flush) begin
      if (!BubbleFlush) begin
        state_d  = StEmpty;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
      end else begin
        if (state_d != StEmpty) begin
          m_ctrl_d = m_ctrl_d & ~KILL_MASK;
        end
        if (state_d == StFull) begin
          s_ctrl_d = s_ctrl_d & ~KILL_MASK;
        end
      end
    end

    ready_d = HasSkid ? (state_d != StFull) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StEmpty;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic elastic pipeline-stage register that replaces the hand-written per-stage registers between CPU stages. Payload width, control width and the flush-kill pattern are parameters. The block adds a valid/ready handshake, an optional 2-entry skid buffer so stall does not ripple combinationally upstream, and two flush modes: drop the beat, or turn it into a bubble. It sits between any two pipeline stages, such as IF/ID, ID/EX, EX/MEM or MEM/WB.

## Interface
- DATA_W, 32: payload width (operands, immediates, pc, register addresses); never modified by flush.
- CTRL_W, 16: control-field width (RegWrite, MemRead, MemWrite, Branch, ...).
- KILL_MASK, {CTRL_W{1'b1}}: ctrl bits forced to 0 by a bubble-mode flush.
- SKID, 1: 1 = 2-entry skid buffer, registered in_ready; 0 = single register, combinational in_ready.
- FLUSH_MODE, 1: 0 = drop (valid cleared); 1 = bubble (valid kept, ctrl masked).
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; reset when 0 at a posedge.
- flush  in  1  kill held entries and the beat accepted this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts (0 = stall).
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control.
- occupancy  out  2  held entries, 0..2 (0..1 when SKID=0).

## Operation
- Reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid empty. in_ready=1 from the first edge after reset is released. A beat presented in a reset cycle is discarded.
- Transfer rules: accept = in_valid & in_ready; fire = out_valid & out_ready. in_data and in_ctrl are don't-care when in_valid=0.
- Storage: main register M drives the outputs. Skid register S exists only when SKID=1.
- SKID=1: in_ready = ~S.valid, registered.
  - State EMPTY (occ 0), accept: M <= in.
  - State ONE (occ 1), fire & accept: M <= in.
  - State ONE, fire & !accept: go to EMPTY.
  - State ONE, !fire & accept: S <= in; go to FULL.
  - State FULL (occ 2), fire: M <= S; S cleared; go to ONE. in_ready is 0 in FULL, so no accept can happen there.
  - Order is strictly FIFO.
- SKID=0: in_ready = ~M.valid | out_ready (combinational from out_ready).
  - accept loads M.
  - fire & !accept empties M.
  - Stall holds M unchanged.
- Flush, FLUSH_MODE=0:
  - Every held entry and the beat accepted that cycle is invalidated; occupancy becomes 0 next cycle.
  - Data and ctrl registers keep their last values.
  - in_ready still reports normally during flush, so the upstream beat is consumed.
- Flush, FLUSH_MODE=1:
  - Every held entry and the accepted beat keep valid and data.
  - Their ctrl becomes ctrl & ~KILL_MASK. Bubbles flow downstream normally.
  - occupancy follows the normal rules.
- Flush with stall: flush wins over hold. The held entry is still killed or masked.
- Flush and fire in the same cycle: the beat on the outputs that cycle is delivered unmodified. Flush takes effect on the register contents after the edge.
- Width rules: payload and ctrl are stored verbatim. KILL_MASK is applied bitwise at CTRL_W width.

## Timing
- Latency: input to output is 1 cycle (accept at edge n, out_valid at edge n+1).
- Throughput: 1 beat/cycle sustained, with out_ready=1 and any SKID.
- SKID=1: in_ready deasserts 1 cycle after the stall that fills S. The at-most-1 beat already in flight lands in S, so no beat is lost or duplicated.
- SKID=1: no combinational path from out_ready or flush to in_ready.
- SKID=0: a combinational path from out_ready to in_ready exists, by design.
- Reset while holding entries: all entries are discarded at that edge; outputs reach reset values 1 cycle later.

## Test plan
- Reset then stream, SKID=1, out_ready=1:
  - Stimulus: hold reset=0 for 2 cycles, then feed data 0x1..0x8 back to back.
  - Required: out_valid=0 and occupancy=0 during reset; outputs 0x1..0x8 each one cycle after acceptance; in_ready never drops.
- Stall fill, SKID=1:
  - Stimulus: feed 0xA, 0xB, 0xC back to back; drop out_ready after 0xA appears.
  - Required: occupancy=2, in_ready=0, 0xC held upstream.
  - Then release out_ready: outputs 0xA, 0xB, 0xC in order with no gaps.
- Bubble flush, FLUSH_MODE=1, KILL_MASK=16'h000F:
  - Stimulus: flush while M holds ctrl=16'h00FF and data 0x1234.
  - Required next cycle: out_valid=1, out_ctrl=16'h00F0, out_data=0x1234.
- Drop flush with accept, FLUSH_MODE=0:
  - Stimulus: occupancy=2, and a flush in the cycle out_ready rises.
  - Required: the current head is delivered; next cycle out_valid=0 and occupancy=0; in_ready=1.
- SKID=0 stall:
  - Stimulus: M holds 0x55, out_ready=0, in_valid=1.
  - Required: in_ready=0 in the same cycle; 0x55 stays on out_data.
  - Then set out_ready=1: in_ready=1 combinationally, and the next beat appears on the following cycle.
- Reset mid-stall:
  - Stimulus: assert reset=0 with occupancy=2.
  - Required next cycle: occupancy=0, out_valid=0, out_data=0, out_ctrl=0.
